// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory stage of the RV32I pipeline.
//
// Purpose:
//   Takes the EX stage result. Non-memory instructions are registered straight
//   through to WB. Loads and stores are issued on a req/gnt/rvalid data-memory
//   bus. Store data is replicated across the byte lanes. Load data is
//   extracted from its lane and then zero- or sign-extended. EX is held via
//   MEM_stall_o while an access is in flight.
//
// Optional feature (compile-time macro MEM_MISALIGN_TRAP_EN):
//   When defined, a misaligned half or word access issues no bus request.
//   It completes immediately with MEM_misaligned_o=1 and MEM_Reg_writeE_o=0.
//   When undefined, no alignment check is made: a half ignores addr[0], a word
//   ignores addr[1:0], and MEM_misaligned_o is tied 0.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   EX_*                     EX stage instruction fields (valid, address/ALU
//                            result, store data, Rd, write enable, WB source,
//                            access size, store flag, load sign)
//   MEM_stall_o              EX must hold its outputs stable
//   dmem_req_o/we/addr/be/wdata, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
//                            data-memory bus
//   MEM_valid_o              one-cycle pulse per completed instruction
//   MEM_ALU_result_o, MEM_Load_data_o, MEM_Rd_o, MEM_Reg_writeE_o,
//   MEM_Rd_source_o, MEM_misaligned_o
//                            registered results to WB
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter logic [1:0] RD_SRC_MEM = 2'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        EX_valid_i,
  input  logic [31:0] EX_ALU_result_i,
  input  logic [31:0] EX_Store_data_i,
  input  logic [4:0]  EX_Rd_i,
  input  logic        EX_Reg_writeE_i,
  input  logic [1:0]  EX_Rd_source_i,
  input  logic [2:0]  EX_Mem_op_size_i,
  input  logic        EX_Mem_Write_i,
  input  logic        EX_Load_sign_i,
  output logic        MEM_stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        MEM_valid_o,
  output logic [31:0] MEM_ALU_result_o,
  output logic [31:0] MEM_Load_data_o,
  output logic [4:0]  MEM_Rd_o,
  output logic        MEM_Reg_writeE_o,
  output logic [1:0]  MEM_Rd_source_o,
  output logic        MEM_misaligned_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  // Byte enables for an access of the given size at byte offset off.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'b001:  lane_be = 4'b0001 << off;
      3'b010:  lane_be = 4'b0011 << {off[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated to every lane the access could target.
  function automatic logic [31:0] lane_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      3'b001:  lane_wdata = {4{d[7:0]}};
      3'b010:  lane_wdata = {2{d[15:0]}};
      default: lane_wdata = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] size, input logic sign);
    logic [31:0] sh;
    case (size)
      3'b001: begin
        sh = rdata >> {off, 3'b000};
        if (sign) load_extract = {{24{sh[7]}}, sh[7:0]};
        else      load_extract = {24'h000000, sh[7:0]};
      end
      3'b010: begin
        sh = rdata >> {off[1], 4'b0000};
        if (sign) load_extract = {{16{sh[15]}}, sh[15:0]};
        else      load_extract = {16'h0000, sh[15:0]};
      end
      default: load_extract = rdata;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // A half access must be half-aligned and a word access word-aligned; a byte access is never misaligned.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'b001:  is_misaligned = 1'b0;
      3'b010:  is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction
`endif

  logic        memop_s;
  logic        mis_s;
  logic        capture_s;
  logic        pass_s;
  logic        complete_s;

  logic [31:0] cap_addr_r;
  logic [2:0]  cap_size_r;
  logic        cap_sign_r;
  logic        cap_we_r;
  logic [4:0]  cap_rd_r;
  logic        cap_regwe_r;
  logic [1:0]  cap_rdsrc_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;

  logic        valid_r;
  logic [31:0] alu_r;
  logic [31:0] ld_r;
  logic [4:0]  rd_r;
  logic        regwe_r;
  logic [1:0]  rdsrc_r;
  logic        mis_r;

  assign memop_s = EX_Mem_Write_i | (EX_Rd_source_i == RD_SRC_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_s = memop_s & is_misaligned(EX_Mem_op_size_i, EX_ALU_result_i[1:0]);
`else
  assign mis_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic plus the capture, pass-through and completion strobes.
  always_comb begin
    state_next_s = state_r;
    capture_s    = 1'b0;
    pass_s       = 1'b0;
    complete_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A trapped misaligned access retires here, like a non-memory op.
        if (EX_valid_i && memop_s && !mis_s) begin
          capture_s    = 1'b1;
          state_next_s = REQ;
        end else if (EX_valid_i) begin
          pass_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (dmem_gnt_i && cap_we_r) begin
          complete_s   = 1'b1;
          state_next_s = IDLE;
        end else if (dmem_gnt_i) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          complete_s   = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Capture the access. Lane enables and replicated data are precomputed so the bus sees flop outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_addr_r  <= 32'h0000_0000;
      cap_size_r  <= 3'b000;
      cap_sign_r  <= 1'b0;
      cap_we_r    <= 1'b0;
      cap_rd_r    <= 5'd0;
      cap_regwe_r <= 1'b0;
      cap_rdsrc_r <= 2'd0;
      be_r        <= 4'b0000;
      wdata_r     <= 32'h0000_0000;
    end else if (capture_s) begin
      cap_addr_r  <= EX_ALU_result_i;
      cap_size_r  <= EX_Mem_op_size_i;
      cap_sign_r  <= EX_Load_sign_i;
      cap_we_r    <= EX_Mem_Write_i;
      cap_rd_r    <= EX_Rd_i;
      cap_regwe_r <= EX_Reg_writeE_i;
      cap_rdsrc_r <= EX_Rd_source_i;
      be_r        <= lane_be(EX_Mem_op_size_i, EX_ALU_result_i[1:0]);
      wdata_r     <= lane_wdata(EX_Mem_op_size_i, EX_Store_data_i);
    end
  end

  // WB result registers; MEM_valid_o pulses for one cycle per retired instruction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
      alu_r   <= 32'h0000_0000;
      ld_r    <= 32'h0000_0000;
      rd_r    <= 5'd0;
      regwe_r <= 1'b0;
      rdsrc_r <= 2'd0;
      mis_r   <= 1'b0;
    end else if (pass_s) begin
      valid_r <= 1'b1;
      alu_r   <= EX_ALU_result_i;
      ld_r    <= 32'h0000_0000;
      rd_r    <= EX_Rd_i;
      regwe_r <= EX_Reg_writeE_i & ~mis_s;
      rdsrc_r <= EX_Rd_source_i;
      mis_r   <= mis_s;
    end else if (complete_s) begin
      valid_r <= 1'b1;
      alu_r   <= cap_addr_r;
      ld_r    <= cap_we_r ? 32'h0000_0000
                          : load_extract(dmem_rdata_i, cap_addr_r[1:0], cap_size_r, cap_sign_r);
      rd_r    <= cap_rd_r;
      regwe_r <= cap_regwe_r;
      rdsrc_r <= cap_rdsrc_r;
      mis_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign MEM_stall_o      = (state_r != IDLE);
  assign dmem_req_o       = (state_r == REQ);
  assign dmem_we_o        = cap_we_r;
  assign dmem_addr_o      = {cap_addr_r[31:2], 2'b00};
  assign dmem_be_o        = be_r;
  assign dmem_wdata_o     = wdata_r;

  assign MEM_valid_o      = valid_r;
  assign MEM_ALU_result_o = alu_r;
  assign MEM_Load_data_o  = ld_r;
  assign MEM_Rd_o         = rd_r;
  assign MEM_Reg_writeE_o = regwe_r;
  assign MEM_Rd_source_o  = rdsrc_r;
  assign MEM_misaligned_o = mis_r;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// A reference model works from access width in bytes and lane arithmetic.
// A bus responder applies configurable gnt and rvalid delays.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        EX_valid_i;
  logic [31:0] EX_ALU_result_i;
  logic [31:0] EX_Store_data_i;
  logic [4:0]  EX_Rd_i;
  logic        EX_Reg_writeE_i;
  logic [1:0]  EX_Rd_source_i;
  logic [2:0]  EX_Mem_op_size_i;
  logic        EX_Mem_Write_i;
  logic        EX_Load_sign_i;
  logic        MEM_stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        MEM_valid_o;
  logic [31:0] MEM_ALU_result_o;
  logic [31:0] MEM_Load_data_o;
  logic [4:0]  MEM_Rd_o;
  logic        MEM_Reg_writeE_o;
  logic [1:0]  MEM_Rd_source_o;
  logic        MEM_misaligned_o;

  mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .EX_valid_i(EX_valid_i), .EX_ALU_result_i(EX_ALU_result_i),
    .EX_Store_data_i(EX_Store_data_i), .EX_Rd_i(EX_Rd_i),
    .EX_Reg_writeE_i(EX_Reg_writeE_i), .EX_Rd_source_i(EX_Rd_source_i),
    .EX_Mem_op_size_i(EX_Mem_op_size_i), .EX_Mem_Write_i(EX_Mem_Write_i),
    .EX_Load_sign_i(EX_Load_sign_i), .MEM_stall_o(MEM_stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .MEM_valid_o(MEM_valid_o), .MEM_ALU_result_o(MEM_ALU_result_o),
    .MEM_Load_data_o(MEM_Load_data_o), .MEM_Rd_o(MEM_Rd_o),
    .MEM_Reg_writeE_o(MEM_Reg_writeE_o), .MEM_Rd_source_o(MEM_Rd_source_o),
    .MEM_misaligned_o(MEM_misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regwe;
    logic [1:0]  rdsrc;
    logic [2:0]  size;
    logic        we;
    logic        sign;
  } op_t;

  // Everything observable about one instruction, compared as one vector.
  typedef struct packed {
    logic        done;
    logic [7:0]  lat;
    logic [7:0]  reqc;
    logic [7:0]  stallc;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        regwe;
    logic [1:0]  rdsrc;
    logic        mis;
  } obs_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected observation for one op under the given bus delays.
  function automatic obs_t model(input op_t op, input int gd, input int rvd, input logic [31:0] rdata);
    obs_t        e;
    int          nb;
    int          o;
    logic        memop;
    logic        mis;
    logic [31:0] msk;
    logic [31:0] v;
    e     = '0;
    e.done = 1'b1;
    nb    = (op.size == 3'd1) ? 1 : ((op.size == 3'd2) ? 2 : 4);
    o     = int'(op.addr[1:0]);
    memop = op.we || (op.rdsrc == 2'd1);
    mis   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis   = memop && ((o % nb) != 0);
`endif
    e.alu   = op.addr;
    e.rd    = op.rd;
    e.rdsrc = op.rdsrc;
    e.regwe = mis ? 1'b0 : op.regwe;
    e.mis   = mis;
    if (!memop || mis) begin
      e.lat = 8'd1;
    end else begin
      o      = o - (o % nb);
      msk    = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      e.we   = op.we;
      e.addr = (op.addr / 32'd4) * 32'd4;
      e.be   = 4'(((1 << nb) - 1) << o);
      e.wdata = 32'd0;
      for (int k = 0; k < 4 / nb; k++) e.wdata = e.wdata | ((op.data & msk) << (8 * nb * k));
      e.reqc = 8'(gd + 1);
      if (op.we) begin
        e.lat = 8'(2 + gd);
      end else begin
        e.lat = 8'(3 + gd + rvd);
        v = (rdata >> (8 * o)) & msk;
        if (op.sign && nb < 4 && v >= (32'd1 << (8 * nb - 1))) v = v | ~msk;
        e.ld = v;
      end
      e.stallc = e.lat - 8'd1;
    end
    return e;
  endfunction

  // Present one op and act as the bus until it retires (bounded at 200 cycles).
  task automatic run_op(input op_t op, input int gd, input int rvd, input logic [31:0] rdata, output obs_t ob);
    bit granted;
    int wcnt;
    int reqn;
    int stn;
    ob = '0; granted = 1'b0; wcnt = 0; reqn = 0; stn = 0;
    EX_valid_i = 1'b1; EX_ALU_result_i = op.addr; EX_Store_data_i = op.data;
    EX_Rd_i = op.rd; EX_Reg_writeE_i = op.regwe; EX_Rd_source_i = op.rdsrc;
    EX_Mem_op_size_i = op.size; EX_Mem_Write_i = op.we; EX_Load_sign_i = op.sign;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = $urandom;
      if (MEM_valid_o) begin
        ob.done = 1'b1; ob.lat = 8'(cyc);
        ob.alu = MEM_ALU_result_o; ob.ld = MEM_Load_data_o; ob.rd = MEM_Rd_o;
        ob.regwe = MEM_Reg_writeE_o; ob.rdsrc = MEM_Rd_source_o; ob.mis = MEM_misaligned_o;
        EX_valid_i = 1'b0;
        break;
      end
      if (MEM_stall_o) stn++;
      else EX_valid_i = 1'b0;
      if (dmem_req_o) begin
        ob.we = dmem_we_o; ob.addr = dmem_addr_o; ob.be = dmem_be_o; ob.wdata = dmem_wdata_o;
        if (reqn == gd) begin
          dmem_gnt_i = 1'b1;
          granted = 1'b1;
        end
        reqn++;
      end else if (granted && !op.we) begin
        if (wcnt == rvd) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = rdata;
        end
        wcnt++;
      end
    end
    EX_valid_i = 1'b0;
    ob.reqc = 8'(reqn);
    ob.stallc = 8'(stn);
  endtask

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                             input logic regwe, input logic [1:0] src, input logic [2:0] sz,
                             input logic we, input logic sg);
    op_t op;
    op.addr = a; op.data = d; op.rd = rd; op.regwe = regwe; op.rdsrc = src;
    op.size = sz; op.we = we; op.sign = sg;
    return op;
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; EX_valid_i = 1'b0; EX_ALU_result_i = 32'd0; EX_Store_data_i = 32'd0;
    EX_Rd_i = 5'd0; EX_Reg_writeE_i = 1'b0; EX_Rd_source_i = 2'd0; EX_Mem_op_size_i = 3'd0;
    EX_Mem_Write_i = 1'b0; EX_Load_sign_i = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (3) @(negedge clk_i);
    n_checks++;
    if ({MEM_stall_o, dmem_req_o, MEM_valid_o, MEM_ALU_result_o, MEM_Load_data_o, MEM_Rd_o,
         MEM_Reg_writeE_o, MEM_Rd_source_o, MEM_misaligned_o, dmem_be_o, dmem_wdata_o} !== 115'd0) begin
      n_fail++;
      $display("FAIL reset_state: outputs not all zero (stall=%b req=%b valid=%b alu=%h)",
               MEM_stall_o, dmem_req_o, MEM_valid_o, MEM_ALU_result_o);
    end
    rst_ni = 1'b1;
    // rvalid while idle must be ignored.
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if ({MEM_valid_o, MEM_stall_o, MEM_Load_data_o} !== 34'd0) begin
      n_fail++;
      $display("FAIL idle_rvalid: valid=%b stall=%b ld=%h, required 0/0/0", MEM_valid_o, MEM_stall_o, MEM_Load_data_o);
    end
  endtask

  task automatic test_alu();
    obs_t ob;
    op_t  op;
    run_op(mk(32'h0000_1234, 32'h0, 5'd5, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0), 0, 0, 32'h0, ob);
    n_checks++;
    if ({ob.done, ob.lat, ob.alu, ob.rd, ob.reqc} !== {1'b1, 8'd1, 32'h0000_1234, 5'd5, 8'd0}) begin
      n_fail++;
      $display("FAIL alu_basic: lat=%0d alu=%h rd=%0d reqs=%0d, required 1/00001234/5/0", ob.lat, ob.alu, ob.rd, ob.reqc);
    end
    for (int i = 0; i < 6; i++) begin
      op = mk($urandom, $urandom, 5'($urandom), 1'($urandom), 2'd0, 3'($urandom), 1'b0, 1'($urandom));
      if (i % 2 == 1) op.rdsrc = 2'd2 + 2'($urandom_range(0, 1));
      run_op(op, 0, 0, 32'h0, ob);
      n_checks++;
      if (ob !== model(op, 0, 0, 32'h0)) begin
        n_fail++;
        $display("FAIL alu_rand: got %h, required %h", ob, model(op, 0, 0, 32'h0));
      end
    end
  endtask

  task automatic test_store();
    obs_t ob;
    op_t  op;
    op = mk(32'h0000_0103, 32'h0000_00AB, 5'd0, 1'b0, 2'd0, 3'd1, 1'b1, 1'b0);
    run_op(op, 2, 0, 32'h0, ob);
    n_checks++;
    if ({ob.reqc, ob.be, ob.wdata, ob.stallc, ob.addr, ob.we, ob.ld} !==
        {8'd3, 4'b1000, 32'hABAB_ABAB, 8'd3, 32'h0000_0100, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL sb_directed: reqs=%0d be=%b wdata=%h stall=%0d addr=%h, required 3/1000/ABABABAB/3/00000100",
               ob.reqc, ob.be, ob.wdata, ob.stallc, ob.addr);
    end
    n_checks++;
    if (ob !== model(op, 2, 0, 32'h0)) begin
      n_fail++;
      $display("FAIL sb_model: got %h, required %h", ob, model(op, 2, 0, 32'h0));
    end
    for (int i = 0; i < 6; i++) begin
      op = mk($urandom, $urandom, 5'($urandom), 1'b0, 2'd0, 3'($urandom_range(0, 3)), 1'b1, 1'b0);
      run_op(op, i % 3, 0, 32'h0, ob);
      n_checks++;
      if (ob !== model(op, i % 3, 0, 32'h0)) begin
        n_fail++;
        $display("FAIL store_rand: got %h, required %h", ob, model(op, i % 3, 0, 32'h0));
      end
    end
  endtask

  task automatic test_load();
    obs_t        ob;
    logic [31:0] rw;
    run_op(mk(32'h0000_0101, 32'h0, 5'd3, 1'b1, 2'd1, 3'd1, 1'b0, 1'b1), 0, 0, 32'h0000_8000, ob);
    n_checks++;
    if (ob.ld !== 32'hFFFF_FF80 || ob.lat !== 8'd3) begin
      n_fail++;
      $display("FAIL lb_signed: ld=%h lat=%0d, required ffffff80/3", ob.ld, ob.lat);
    end
    run_op(mk(32'h0000_0101, 32'h0, 5'd3, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0), 0, 0, 32'h0000_8000, ob);
    n_checks++;
    if (ob.ld !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu: ld=%h, required 00000080", ob.ld);
    end
    run_op(mk(32'h0000_0102, 32'h0, 5'd4, 1'b1, 2'd1, 3'd2, 1'b0, 1'b1), 1, 0, 32'h8001_0000, ob);
    n_checks++;
    if (ob.ld !== 32'hFFFF_8001 || ob.be !== 4'b1100) begin
      n_fail++;
      $display("FAIL lh_signed: ld=%h be=%b, required ffff8001/1100", ob.ld, ob.be);
    end
    rw = $urandom;
    run_op(mk(32'h0000_0200, 32'h0, 5'd9, 1'b1, 2'd1, 3'd3, 1'b0, 1'b1), 0, 4, rw, ob);
    n_checks++;
    if ({ob.ld, ob.stallc, ob.lat, ob.rd} !== {rw, 8'd6, 8'd7, 5'd9}) begin
      n_fail++;
      $display("FAIL lw_wait4: ld=%h stall=%0d lat=%0d, required %h/6/7", ob.ld, ob.stallc, ob.lat, rw);
    end
  endtask

  task automatic test_misaligned();
    obs_t ob;
    op_t  op;
    op = mk(32'h0000_0102, 32'h0, 5'd8, 1'b1, 2'd1, 3'd3, 1'b0, 1'b0);
    run_op(op, 0, 0, 32'h1357_9BDF, ob);
    n_checks++;
    if (ob !== model(op, 0, 0, 32'h1357_9BDF)) begin
      n_fail++;
      $display("FAIL lw_misaligned_model: got %h, required %h", ob, model(op, 0, 0, 32'h1357_9BDF));
    end
`ifdef MEM_MISALIGN_TRAP_EN
    n_checks++;
    if ({ob.reqc, ob.mis, ob.regwe, ob.lat} !== {8'd0, 1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL lw_trap: reqs=%0d mis=%b we=%b lat=%0d, required 0/1/0/1", ob.reqc, ob.mis, ob.regwe, ob.lat);
    end
`else
    n_checks++;
    if ({ob.reqc, ob.mis, ob.addr, ob.be, ob.ld} !== {8'd1, 1'b0, 32'h0000_0100, 4'hF, 32'h1357_9BDF}) begin
      n_fail++;
      $display("FAIL lw_no_trap: reqs=%0d mis=%b addr=%h be=%b ld=%h", ob.reqc, ob.mis, ob.addr, ob.be, ob.ld);
    end
`endif
  endtask

  task automatic test_back_to_back();
    obs_t        ob;
    op_t         op;
    int          kind;
    int          gd;
    int          rvd;
    logic [31:0] rdv;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      gd   = $urandom_range(0, 3);
      rvd  = $urandom_range(0, 3);
      rdv  = $urandom;
      op   = mk($urandom, $urandom, 5'($urandom), 1'($urandom), 2'd0, 3'($urandom), 1'b0, 1'($urandom));
      if (kind == 1) begin op.we = 1'b1; op.regwe = 1'b0; end
      else if (kind == 2) begin op.rdsrc = 2'd1; op.regwe = 1'b1; end
      else begin op.rdsrc = (i % 2 == 0) ? 2'd0 : 2'd2; end
      run_op(op, gd, rvd, rdv, ob);
      n_checks++;
      if (ob !== model(op, gd, rvd, rdv)) begin
        n_fail++;
        $display("FAIL b2b_%0d kind=%0d: got %h, required %h", i, kind, ob, model(op, gd, rvd, rdv));
      end
    end
    @(negedge clk_i);
    n_checks++;
    if (MEM_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_pulse: MEM_valid_o=%b one cycle after retire, required 0", MEM_valid_o);
    end
  endtask

  task automatic test_reset_in_wait();
    int vseen;
    int sseen;
    EX_valid_i = 1'b1; EX_ALU_result_i = 32'h0000_0340; EX_Rd_i = 5'd7; EX_Reg_writeE_i = 1'b1;
    EX_Rd_source_i = 2'd1; EX_Mem_op_size_i = 3'd3; EX_Mem_Write_i = 1'b0; EX_Load_sign_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({dmem_req_o, MEM_stall_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_wait_req: req=%b stall=%b, required 1/1", dmem_req_o, MEM_stall_o);
    end
    dmem_gnt_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    n_checks++;
    if ({dmem_req_o, MEM_stall_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_wait_state: req=%b stall=%b, required 0/1", dmem_req_o, MEM_stall_o);
    end
    rst_ni = 1'b0; EX_valid_i = 1'b0;
    #1;
    n_checks++;
    if ({MEM_stall_o, dmem_req_o, MEM_valid_o, MEM_ALU_result_o, MEM_Load_data_o, MEM_Rd_o,
         MEM_Reg_writeE_o, MEM_Rd_source_o, MEM_misaligned_o, dmem_be_o, dmem_addr_o} !== 115'd0) begin
      n_fail++;
      $display("FAIL rst_async: stall=%b req=%b alu=%h rd=%0d addr=%h, required all 0",
               MEM_stall_o, dmem_req_o, MEM_ALU_result_o, MEM_Rd_o, dmem_addr_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    vseen = 0; sseen = 0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      dmem_rvalid_i = 1'b0;
      if (MEM_valid_o) vseen++;
      if (MEM_stall_o || dmem_req_o) sseen++;
    end
    n_checks++;
    if (vseen != 0 || sseen != 0) begin
      n_fail++;
      $display("FAIL rst_late_rvalid: valid pulses=%0d busy cycles=%0d, required 0/0", vseen, sseen);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misaligned();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
